// File: rtl/conbus_mxn_pkg.sv
// Shared constants, types and helpers for the conbus_mxn Wishbone crossbar.
// CTI encodings are used by masters and test code; the error FSM state type lives here too.
package conbus_mxn_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        ERR_IDLE  = 1'b0,
        ERR_PULSE = 1'b1
    } err_state_e;

    // Ceiling log2, at least 1 so a select signal always has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conbus_arb_rr.sv
// Round-robin arbiter: the grant is held while the owner keeps req high, then passes
// to the next requester in circular order on the following edge.
module conbus_arb_rr
    import conbus_mxn_pkg::*;
#(
    parameter int NM = 5,
    parameter int GW = clog2(NM)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [NM-1:0] req,
    output logic [GW-1:0] gnt
);

    logic [GW-1:0] gnt_q;
    logic [GW-1:0] gnt_d;
    logic [GW-1:0] cand;

    // Scan from the farthest candidate down so the nearest requester after gnt_q wins.
    always_comb begin
        gnt_d = gnt_q;
        cand  = gnt_q;
        if (!req[gnt_q]) begin
            for (int i = NM - 1; i >= 1; i--) begin
                cand = GW'((int'(gnt_q) + i) % NM);
                if (req[cand]) begin
                    gnt_d = cand;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/conbus_mxn.sv
// NM-master to NS-slave Wishbone shared bus with round-robin arbitration, base/mask decode,
// one-cycle error termination for unmapped accesses and a stalled-slave watchdog.
module conbus_mxn
    import conbus_mxn_pkg::*;
#(
    parameter int              NM         = 5,
    parameter int              NS         = 6,
    parameter logic [NS*32-1:0] SLAVE_BASE = {32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
                                              32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NS*32-1:0] SLAVE_MASK = {NS{32'hF000_0000}},
    parameter logic [7:0]      TIMEOUT    = 8'd255
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NM*32-1:0]    m_adr_i,
    input  logic [NM*32-1:0]    m_dat_i,
    input  logic [NM*3-1:0]     m_cti_i,
    input  logic [NM*4-1:0]     m_sel_i,
    input  logic [NM-1:0]       m_we_i,
    input  logic [NM-1:0]       m_cyc_i,
    input  logic [NM-1:0]       m_stb_i,
    output logic [31:0]         m_dat_o,
    output logic [NM-1:0]       m_ack_o,
    output logic [NM-1:0]       m_err_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [2:0]          s_cti_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic [NS-1:0]       s_cyc_o,
    output logic [NS-1:0]       s_stb_o,
    input  logic [NS*32-1:0]    s_dat_i,
    input  logic [NS-1:0]       s_ack_i,
    input  logic [NS-1:0]       s_err_i,
    output logic [NS-1:0]       slave_selected
);

    localparam int GW = clog2(NM);

    logic [GW-1:0] gnt;
    logic [31:0]   adr_a [NM];
    logic [31:0]   wdat_a [NM];
    logic [2:0]    cti_a [NM];
    logic [3:0]    sel_a [NM];
    logic [31:0]   rdat_a [NS];
    logic [NS-1:0] dec_raw;
    logic [NS-1:0] hit;
    logic          cyc;
    logic          stb;
    logic          ack;
    logic          err;
    logic          unmapped;
    logic          pending;
    logic          wd_expire;
    logic [7:0]    wd_q;
    logic [7:0]    wd_d;
    err_state_e    err_q;
    err_state_e    err_d;

    conbus_arb_rr #(
        .NM (NM),
        .GW (GW)
    ) u_arb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (m_cyc_i),
        .gnt     (gnt)
    );

    for (genvar k = 0; k < NM; k++) begin : g_master
        assign adr_a[k]  = m_adr_i[32*k +: 32];
        assign wdat_a[k] = m_dat_i[32*k +: 32];
        assign cti_a[k]  = m_cti_i[3*k +: 3];
        assign sel_a[k]  = m_sel_i[4*k +: 4];
    end

    assign s_adr_o = adr_a[gnt];
    assign s_dat_o = wdat_a[gnt];
    assign s_cti_o = cti_a[gnt];
    assign s_sel_o = sel_a[gnt];
    assign s_we_o  = m_we_i[gnt];
    assign cyc     = m_cyc_i[gnt];
    assign stb     = m_stb_i[gnt];

    for (genvar i = 0; i < NS; i++) begin : g_slave
        assign dec_raw[i] = (s_adr_o & SLAVE_MASK[32*i +: 32]) ==
                            (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]);
        assign rdat_a[i]  = s_dat_i[32*i +: 32];
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest slave index.
    assign hit = dec_raw & (~dec_raw + NS'(1));

    assign s_cyc_o        = hit & {NS{cyc}};
    assign s_stb_o        = hit & {NS{stb}};
    assign slave_selected = hit & {NS{cyc}};

    always_comb begin
        m_dat_o = '0;
        for (int i = 0; i < NS; i++) begin
            if (hit[i]) begin
                m_dat_o = rdat_a[i];
            end
        end
    end

    assign ack      = |(s_ack_i & hit);
    assign err      = ((|(s_err_i & hit)) | (err_q == ERR_PULSE)) & ~ack;
    assign unmapped = cyc & stb & ~(|hit);

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (!sys_rst) begin
            m_ack_o[gnt] = ack;
            m_err_o[gnt] = err;
        end
    end

    // Anything but a live, unterminated mapped access clears the count; a grant change
    // is covered because the previous owner's cyc is low in the cycle it happens.
    assign pending = cyc & stb & (|hit) & ~ack & ~err;

    always_comb begin
        wd_d      = '0;
        wd_expire = 1'b0;
        if (pending && (TIMEOUT != 8'd0)) begin
            if (wd_q == TIMEOUT - 8'd1) begin
                wd_expire = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
    end

    // A pulse always lasts exactly one cycle and is followed by at least one quiet cycle.
    always_comb begin
        err_d = ERR_IDLE;
        case (err_q)
            ERR_IDLE:  err_d = (unmapped || wd_expire) ? ERR_PULSE : ERR_IDLE;
            ERR_PULSE: err_d = ERR_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            err_q <= ERR_IDLE;
            wd_q  <= '0;
        end else begin
            err_q <= err_d;
            wd_q  <= wd_d;
        end
    end

endmodule

// File: tb/tb_conbus_mxn.sv
// Directed bench for conbus_mxn: 5 masters, 6 slaves on 512 MiB windows, TIMEOUT=8.
module tb_conbus_mxn;
    import conbus_mxn_pkg::*;

    localparam int NM = 5;
    localparam int NS = 6;
    localparam logic [NS*32-1:0] BASE = {32'hA000_0000, 32'h8000_0000, 32'h6000_0000,
                                         32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {NS{32'hE000_0000}};

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic [NM*32-1:0]   m_adr_i;
    logic [NM*32-1:0]   m_dat_i;
    logic [NM*3-1:0]    m_cti_i;
    logic [NM*4-1:0]    m_sel_i;
    logic [NM-1:0]      m_we_i;
    logic [NM-1:0]      m_cyc_i;
    logic [NM-1:0]      m_stb_i;
    logic [31:0]        m_dat_o;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;
    logic [31:0]        s_adr_o;
    logic [31:0]        s_dat_o;
    logic [2:0]         s_cti_o;
    logic [3:0]         s_sel_o;
    logic               s_we_o;
    logic [NS-1:0]      s_cyc_o;
    logic [NS-1:0]      s_stb_o;
    logic [NS*32-1:0]   s_dat_i;
    logic [NS-1:0]      s_ack_i;
    logic [NS-1:0]      s_err_i;
    logic [NS-1:0]      slave_selected;

    logic [NS-1:0]      ack_man;
    logic               auto_ack;

    int n_checks = 0;
    int n_errors = 0;

    int   owner [$];
    logic act [NM];
    int   beats [NM];
    int   bursts [NM];

    assign s_ack_i = ack_man | (s_stb_o & {NS{auto_ack}});

    always #5 sys_clk = ~sys_clk;

    conbus_mxn #(
        .NM         (NM),
        .NS         (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (8'd8)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .m_adr_i        (m_adr_i),
        .m_dat_i        (m_dat_i),
        .m_cti_i        (m_cti_i),
        .m_sel_i        (m_sel_i),
        .m_we_i         (m_we_i),
        .m_cyc_i        (m_cyc_i),
        .m_stb_i        (m_stb_i),
        .m_dat_o        (m_dat_o),
        .m_ack_o        (m_ack_o),
        .m_err_o        (m_err_o),
        .s_adr_o        (s_adr_o),
        .s_dat_o        (s_dat_o),
        .s_cti_o        (s_cti_o),
        .s_sel_o        (s_sel_o),
        .s_we_o         (s_we_o),
        .s_cyc_o        (s_cyc_o),
        .s_stb_o        (s_stb_o),
        .s_dat_i        (s_dat_i),
        .s_ack_i        (s_ack_i),
        .s_err_i        (s_err_i),
        .slave_selected (slave_selected)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    task automatic set_master(input int k, input logic on, input logic [31:0] adr,
                              input logic [2:0] cti);
        m_cyc_i[k]          = on;
        m_stb_i[k]          = on;
        m_we_i[k]           = 1'b0;
        m_adr_i[32*k +: 32] = adr;
        m_dat_i[32*k +: 32] = ~adr;
        m_cti_i[3*k +: 3]   = cti;
        m_sel_i[4*k +: 4]   = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not finish within 100000 ns");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        sys_rst  = 1'b1;
        ack_man  = '0;
        auto_ack = 1'b0;
        s_err_i  = '0;
        for (int k = 0; k < NM; k++) begin
            set_master(k, 1'b0, 32'hE000_0000, CTI_CLASSIC);
            act[k]    = 1'b0;
            beats[k]  = 0;
            bursts[k] = 0;
        end
        for (int i = 0; i < NS; i++) begin
            s_dat_i[32*i +: 32] = 32'h5100_0000 + i;
        end

        // Reset state
        step();
        step();
        sample();
        check("rst_ack_forced", m_ack_o, 5'b00000);
        check("rst_err_forced", m_err_o, 5'b00000);
        step();
        sys_rst = 1'b0;
        sample();
        check("rst_sel", slave_selected, 6'b000000);
        check("rst_scyc", s_cyc_o, 6'b000000);
        check("rst_dat", m_dat_o, 32'h0);
        check("rst_ack", m_ack_o, 5'b00000);
        check("rst_err", m_err_o, 5'b00000);

        // 1: m0 reads 0x10, slave 0 acks in the second cycle
        step();
        set_master(0, 1'b1, 32'h0000_0010, CTI_CLASSIC);
        sample();
        check("t1_scyc", s_cyc_o, 6'b000001);
        check("t1_sel", slave_selected, 6'b000001);
        check("t1_adr", s_adr_o, 32'h0000_0010);
        check("t1_wdat", s_dat_o, 32'hFFFF_FFEF);
        check("t1_we", s_we_o, 1'b0);
        check("t1_bsel", s_sel_o, 4'hF);
        check("t1_ack_wait", m_ack_o, 5'b00000);
        step();
        ack_man[0]       = 1'b1;
        s_dat_i[31:0]    = 32'hDEAD_BEEF;
        sample();
        check("t1_rdat", m_dat_o, 32'hDEAD_BEEF);
        check("t1_ack", m_ack_o, 5'b00001);
        check("t1_err", m_err_o, 5'b00000);
        step();
        ack_man = '0;
        set_master(0, 1'b0, 32'hE000_0000, CTI_CLASSIC);

        // 2: m1 and m3 contend with 4-beat INCR bursts, one idle cycle between bursts
        step();
        auto_ack = 1'b1;
        act[1]   = 1'b1;
        act[3]   = 1'b1;
        set_master(1, 1'b1, 32'h2000_0100, CTI_INCR);
        set_master(3, 1'b1, 32'h4000_0300, CTI_INCR);
        for (int n = 0; n < 100 && owner.size() < 16; n++) begin
            sample();
            for (int k = 1; k <= 3; k += 2) begin
                if (!act[k]) begin
                    if (bursts[k] < 2) act[k] = 1'b1;
                end else if (m_ack_o[k]) begin
                    owner.push_back(k);
                    beats[k]++;
                    if (beats[k] == 4) begin
                        check("t2_eob", s_cti_o, CTI_EOB);
                        beats[k]  = 0;
                        bursts[k]++;
                        act[k]    = 1'b0;
                    end
                end
            end
            step();
            for (int k = 1; k <= 3; k += 2) begin
                set_master(k, act[k], (k == 1) ? 32'h2000_0100 : 32'h4000_0300,
                           (beats[k] == 3) ? CTI_EOB : CTI_INCR);
            end
        end
        check("t2_beats", owner.size(), 16);
        for (int i = 0; i < owner.size(); i++) begin
            check("t2_owner", owner[i], ((i / 4) % 2 == 0) ? 1 : 3);
        end
        for (int k = 0; k < NM; k++) begin
            set_master(k, 1'b0, 32'hE000_0000, CTI_CLASSIC);
        end
        auto_ack = 1'b0;

        // 3: unmapped access by m3 (still granted); stb held for two error periods
        step();
        set_master(3, 1'b1, 32'hC000_0000, CTI_CLASSIC);
        sample();
        check("t3_scyc", s_cyc_o, 6'b000000);
        check("t3_dat_zero", m_dat_o, 32'h0);
        check("t3_err_n0", m_err_o, 5'b00000);
        step();
        sample();
        check("t3_err_n1", m_err_o, 5'b01000);
        step();
        sample();
        check("t3_err_n2", m_err_o, 5'b00000);
        step();
        sample();
        check("t3_err_n3", m_err_o, 5'b01000);
        step();
        set_master(3, 1'b0, 32'hE000_0000, CTI_CLASSIC);
        sample();
        check("t3_err_idle", m_err_o, 5'b00000);

        // 4: slave 3 never acks; watchdog fires after 8 cycles, then again 9 cycles later
        step();
        set_master(3, 1'b1, 32'h6000_0000, CTI_CLASSIC);
        for (int c = 0; c < 18; c++) begin
            sample();
            check("t4_wd_err", m_err_o, (c == 8 || c == 17) ? 5'b01000 : 5'b00000);
            step();
        end
        set_master(3, 1'b0, 32'hE000_0000, CTI_CLASSIC);

        // 5: ack+err in the cycle the watchdog would expire; then slave error alone
        step();
        set_master(3, 1'b1, 32'h6000_0000, CTI_CLASSIC);
        for (int c = 0; c < 18; c++) begin
            ack_man[3] = (c == 7);
            s_err_i[3] = (c == 7 || c == 17);
            sample();
            check("t5_ack", m_ack_o, (c == 7) ? 5'b01000 : 5'b00000);
            check("t5_err", m_err_o, (c == 16 || c == 17) ? 5'b01000 : 5'b00000);
            step();
        end
        ack_man = '0;
        s_err_i = '0;
        set_master(3, 1'b0, 32'hE000_0000, CTI_CLASSIC);

        // 6: reset in the middle of an m2 burst
        step();
        auto_ack = 1'b1;
        set_master(2, 1'b1, 32'h8000_0000, CTI_INCR);
        sample();
        check("t6_ack_pre", m_ack_o, 5'b00000);
        step();
        sample();
        check("t6_ack_m2", m_ack_o, 5'b00100);
        step();
        auto_ack = 1'b0;
        step();
        sys_rst    = 1'b1;
        ack_man[4] = 1'b1;
        sample();
        check("t6_ack_in_rst", m_ack_o, 5'b00000);
        check("t6_err_in_rst", m_err_o, 5'b00000);
        step();
        sys_rst = 1'b0;
        ack_man = '0;
        sample();
        check("t6_scyc_gnt0", s_cyc_o, 6'b000000);
        check("t6_ack_after", m_ack_o, 5'b00000);
        check("t6_err_after", m_err_o, 5'b00000);
        step();
        sample();
        check("t6_regrant_m2", s_cyc_o, 6'b010000);
        step();
        set_master(2, 1'b0, 32'hE000_0000, CTI_CLASSIC);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
